multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter ALUOP_W, default 3, sets AluOperation width; values must be >=3 and upper bits are zero-filled.
REQ-002 Parameter MEM_TIMEOUT, default 15, sets the maximum number of mem_ready wait cycles per memory access before a trap.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opcode, func  input  6 each  fields of the instruction register, valid from DECODE onward.
REQ-006 zero  input  1  ALU zero flag, sampled in BRANCH.
REQ-007 mem_ready  input  1  memory handshake; access completes in a cycle with MemRead/MemWrite=1 and mem_ready=1.
REQ-008 IorD, IRWrite, PCWrite, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite  output  1 each  datapath controls.
REQ-009 PCSrc  output  2  PC source: 00 ALU result, 01 ALUOut (branch target), 10 jump target, 11 register rs (jr).
REQ-010 ALUSrcB  output  2  ALU operand B: 00 rt, 01 constant 4, 10 sign-extended immediate, 11 shifted immediate.
REQ-011 RegDst  output  2  destination register: 00 rt, 01 rd, 10 r31.
REQ-012 AluOperation  output  ALUOP_W  ALU code: add=010, sub=011, slt=100.
REQ-013 instr_done  output  1  one-cycle pulse in the final cycle of each retired instruction.
REQ-014 err  output  1  sticky trap flag.

Function
REQ-015 The controller SHALL be a Moore FSM with states FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR and TRAP; outputs not listed for a state are 0.
REQ-016 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, add and PCSrc=00, and SHALL assert IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE; otherwise it stays in FETCH.
REQ-017 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11 and add, then branch on opcode: 000000 with func 001000 -> JR; other 000000 -> EXEC_R; addi(001000)/addiu(001001)/slti(001010) -> EXEC_I; lw(100011)/sw(101011) -> MEM_ADDR; beq(000100) -> BRANCH; j(000010) -> JUMP; jal(000011) -> JAL; any other opcode -> TRAP.
REQ-018 In EXEC_R, AluOperation SHALL be func[2:0], except func 100010 gives 011 and func 101010 gives 100; ALUSrcA=1 and ALUSrcB=00.
REQ-019 EXEC_I SHALL drive ALUSrcA=1, ALUSrcB=10, with add for addi/addiu and 100 for slti; MEM_ADDR SHALL drive the same operand selects with add.
REQ-020 MEM_RD SHALL drive MemRead=1, IorD=1 and wait for mem_ready, then go to WB_MEM; MEM_WR SHALL drive MemWrite=1, IorD=1 and wait for mem_ready, then retire.
REQ-021 WB_R SHALL drive RegWrite=1, RegDst=01; WB_I SHALL drive RegWrite=1, RegDst=00; WB_MEM SHALL drive RegWrite=1, RegDst=00, MemtoReg=1.
REQ-022 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, sub, PCSrc=01, with PCWrite=zero.
REQ-023 JUMP SHALL drive PCWrite=1, PCSrc=10; JAL SHALL do the same plus RegWrite=1 and RegDst=10; JR SHALL drive PCWrite=1, PCSrc=11.
REQ-024 Latency with zero wait states SHALL be: lw 5 cycles; R-type, I-type ALU and sw 4 cycles; beq, j, jal and jr 3 cycles, FETCH included.
REQ-025 instr_done SHALL pulse in WB_R, WB_I, WB_MEM, BRANCH, JUMP, JAL, JR, and in the MEM_WR cycle with mem_ready=1; every retiring state SHALL return to FETCH.
REQ-026 A wait counter SHALL clear on entry to FETCH, MEM_RD or MEM_WR and increment on each mem_ready=0 cycle; when it reaches MEM_TIMEOUT with mem_ready=0, the next state SHALL be TRAP.
REQ-027 In TRAP, all write enables SHALL be 0 and err=1; the FSM SHALL stay in TRAP until rst.
REQ-028 If mem_ready=1 in the same cycle the counter reaches MEM_TIMEOUT, the access SHALL complete normally (no trap).

Reset
REQ-029 While rst=1, state SHALL be FETCH, the wait counter 0, err 0, and every output 0 (gated) regardless of clk.
REQ-030 Reset asserted mid-instruction SHALL abort it with no further write-enable pulses.
REQ-031 The first cycle after release SHALL show FETCH outputs.

Configuration
REQ-032 With macro MULTICYCLE_BNE_EN defined, opcode 000101 (bne) SHALL go to BRANCH with PCWrite=~zero.
REQ-033 Without MULTICYCLE_BNE_EN, opcode 000101 SHALL go to TRAP.

Verification
REQ-034 add (op 000000, func 100000), mem_ready=1 -> 4 cycles; AluOperation=000 in EXEC_R, RegWrite=1 and RegDst=01 in WB_R, instr_done pulses once.
REQ-035 lw with mem_ready low for 3 cycles in MEM_RD -> MemRead held 4 cycles; WB_MEM has MemtoReg=1; total 8 cycles.
REQ-036 beq with zero=1 -> PCWrite=1 and PCSrc=01 in BRANCH; with zero=0 -> PCWrite=0; both take 3 cycles.
REQ-037 mem_ready held 0 in FETCH with MEM_TIMEOUT=15 -> TRAP after 16 cycles and err=1; asserting rst clears err and returns to FETCH.
REQ-038 opcode 000101 -> BRANCH with MULTICYCLE_BNE_EN defined, TRAP without it; opcode 111111 -> TRAP in both builds.
REQ-039 rst pulsed during MEM_WR -> MemWrite drops immediately; next instruction starts cleanly from FETCH.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle MIPS-subset control unit: a Moore FSM that sequences FETCH,
// DECODE, execute, memory and write-back steps and drives the datapath
// selects and write enables. A wait counter guards every memory handshake
// and sends the FSM to a sticky TRAP state if memory stalls too long.
// ALUOP_W must be at least 3; the ALU code is zero-extended to that width.
// Optional feature: define MULTICYCLE_BNE_EN to decode bne (opcode 000101)
// as a branch taken on ~zero; without it bne is an illegal opcode.
module multicycle_controller #(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic [5:0]         func,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               IorD,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               ALUSrcA,
  output logic               MemtoReg,
  output logic               RegWrite,
  output logic               MemRead,
  output logic               MemWrite,
  output logic [1:0]         PCSrc,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         RegDst,
  output logic [ALUOP_W-1:0] AluOperation,
  output logic               instr_done,
  output logic               err
);

  localparam int CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

`ifdef MULTICYCLE_BNE_EN
  localparam bit BNE_EN = 1'b1;
`else
  localparam bit BNE_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_JAL,
    S_JR,
    S_TRAP
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] wait_cnt;
  logic [2:0]       alu_op;
  logic             is_wait_state;
  logic             timeout;
  logic             is_bne;

  assign is_wait_state = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  assign timeout       = !mem_ready && (wait_cnt == CNT_W'(MEM_TIMEOUT));
  assign is_bne        = BNE_EN && (opcode == OP_BNE);

  // State register; reset drops the FSM back to FETCH at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter: cleared when a handshake state is entered, counts stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((next_state != state) &&
                 ((next_state == S_FETCH) || (next_state == S_MEM_RD) ||
                  (next_state == S_MEM_WR))) begin
      wait_cnt <= '0;
    end else if (is_wait_state && !mem_ready && (next_state == state)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Next-state and per-state outputs; everything is forced low during reset.
  always_comb begin
    next_state   = state;
    IorD         = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    ALUSrcA      = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    PCSrc        = 2'b00;
    ALUSrcB      = 2'b00;
    RegDst       = 2'b00;
    alu_op       = 3'b000;
    instr_done   = 1'b0;
    err          = 1'b0;
    AluOperation = '0;

    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        alu_op  = ALU_ADD;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        alu_op  = ALU_ADD;
        case (opcode)
          OP_RTYPE:                  next_state = (func == FN_JR) ? S_JR : S_EXEC_R;
          OP_ADDI, OP_ADDIU, OP_SLTI: next_state = S_EXEC_I;
          OP_LW, OP_SW:              next_state = S_MEM_ADDR;
          OP_BEQ:                    next_state = S_BRANCH;
          OP_J:                      next_state = S_JUMP;
          OP_JAL:                    next_state = S_JAL;
          default:                   next_state = is_bne ? S_BRANCH : S_TRAP;
        endcase
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        if (func == FN_SUB) begin
          alu_op = ALU_SUB;
        end else if (func == FN_SLT) begin
          alu_op = ALU_SLT;
        end else begin
          alu_op = func[2:0];
        end
        next_state = S_WB_R;
      end
      S_EXEC_I: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        alu_op     = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        next_state = S_WB_I;
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        alu_op     = ALU_ADD;
        next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          next_state = S_WB_MEM;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end
      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          next_state = S_FETCH;
        end else if (timeout) begin
          next_state = S_TRAP;
        end
      end
      S_WB_R: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_I: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_WB_MEM: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        alu_op     = ALU_SUB;
        PCSrc      = 2'b01;
        PCWrite    = is_bne ? ~zero : zero;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JAL: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b10;
        RegWrite   = 1'b1;
        RegDst     = 2'b10;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_JR: begin
        PCWrite    = 1'b1;
        PCSrc      = 2'b11;
        instr_done = 1'b1;
        next_state = S_FETCH;
      end
      S_TRAP: begin
        err        = 1'b1;
        next_state = S_TRAP;
      end
      default: begin
        next_state = S_TRAP;
      end
    endcase

    if (rst) begin
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      ALUSrcA    = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      PCSrc      = 2'b00;
      ALUSrcB    = 2'b00;
      RegDst     = 2'b00;
      alu_op     = 3'b000;
      instr_done = 1'b0;
      err        = 1'b0;
    end

    AluOperation = ALUOP_W'(alu_op);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a cycle-by-cycle vector
// table covering every instruction class, plus hand-written sequences for
// memory timeout, the timeout boundary and reset during a store.
module tb_multicycle_controller;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_JR  = 6'b001000;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;
  logic       IorD, IRWrite, PCWrite, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite;
  logic [1:0] PCSrc, ALUSrcB, RegDst;
  logic [2:0] AluOperation;
  logic       instr_done, err;
  logic [18:0] act;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .func         (func),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .IorD         (IorD),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .ALUSrcA      (ALUSrcA),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .PCSrc        (PCSrc),
    .ALUSrcB      (ALUSrcB),
    .RegDst       (RegDst),
    .AluOperation (AluOperation),
    .instr_done   (instr_done),
    .err          (err)
  );

  assign act = {IorD, IRWrite, PCWrite, ALUSrcA, MemtoReg, RegWrite, MemRead, MemWrite,
                PCSrc, ALUSrcB, RegDst, AluOperation, instr_done, err};

  typedef struct {
    logic        r;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic        z;
    logic        rdy;
    logic [18:0] expv;
    string       name;
  } vec_t;

  vec_t vecs[$];

  logic [18:0] E_ZERO, E_FETCH_W, E_FETCH_R, E_DECODE;
  logic [18:0] E_EXR_ADD, E_EXR_SUB, E_EXR_SLT, E_EXR_OR, E_WB_R;
  logic [18:0] E_EXI_ADD, E_EXI_SLT, E_WB_I, E_MRD, E_WB_MEM, E_MWR_W, E_MWR_R;
  logic [18:0] E_BR_T, E_BR_N, E_JUMP, E_JAL, E_JR, E_TRAP;

  function automatic logic [18:0] mk(input logic iord, irw, pcw, srca, m2r, rw, mr, mw,
                                     input logic [1:0] pcsrc, srcb, regdst,
                                     input logic [2:0] alu, input logic done, e);
    return {iord, irw, pcw, srca, m2r, rw, mr, mw, pcsrc, srcb, regdst, alu, done, e};
  endfunction

  function automatic void add(input logic r, input logic [5:0] op, fn, input logic z, rdy,
                              input logic [18:0] expv, input string name);
    vec_t v;
    v.r = r; v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.expv = expv; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input logic r, input logic [5:0] op, fn, input logic z, rdy);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    func      = fn;
    zero      = z;
    mem_ready = rdy;
  endtask

  task automatic checkOutput(input string name, input logic [18:0] expv);
    #1;
    total++;
    if (act === expv) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: actual=%05h required=%05h", name, act, expv);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = OP_R; func = FN_ADD; zero = 1'b0; mem_ready = 1'b0;

    E_ZERO    = mk(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0,0);
    E_FETCH_W = mk(0,0,0,0,0,0,1,0, 2'b00,2'b01,2'b00, 3'b010, 0,0);
    E_FETCH_R = mk(0,1,1,0,0,0,1,0, 2'b00,2'b01,2'b00, 3'b010, 0,0);
    E_DECODE  = mk(0,0,0,0,0,0,0,0, 2'b00,2'b11,2'b00, 3'b010, 0,0);
    E_EXR_ADD = mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0,0);
    E_EXR_SUB = mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b011, 0,0);
    E_EXR_SLT = mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b100, 0,0);
    E_EXR_OR  = mk(0,0,0,1,0,0,0,0, 2'b00,2'b00,2'b00, 3'b101, 0,0);
    E_WB_R    = mk(0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b01, 3'b000, 1,0);
    E_EXI_ADD = mk(0,0,0,1,0,0,0,0, 2'b00,2'b10,2'b00, 3'b010, 0,0);
    E_EXI_SLT = mk(0,0,0,1,0,0,0,0, 2'b00,2'b10,2'b00, 3'b100, 0,0);
    E_WB_I    = mk(0,0,0,0,0,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 1,0);
    E_MRD     = mk(1,0,0,0,0,0,1,0, 2'b00,2'b00,2'b00, 3'b000, 0,0);
    E_WB_MEM  = mk(0,0,0,0,1,1,0,0, 2'b00,2'b00,2'b00, 3'b000, 1,0);
    E_MWR_W   = mk(1,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 0,0);
    E_MWR_R   = mk(1,0,0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 1,0);
    E_BR_T    = mk(0,0,1,1,0,0,0,0, 2'b01,2'b00,2'b00, 3'b011, 1,0);
    E_BR_N    = mk(0,0,0,1,0,0,0,0, 2'b01,2'b00,2'b00, 3'b011, 1,0);
    E_JUMP    = mk(0,0,1,0,0,0,0,0, 2'b10,2'b00,2'b00, 3'b000, 1,0);
    E_JAL     = mk(0,0,1,0,0,1,0,0, 2'b10,2'b00,2'b10, 3'b000, 1,0);
    E_JR      = mk(0,0,1,0,0,0,0,0, 2'b11,2'b00,2'b00, 3'b000, 1,0);
    E_TRAP    = mk(0,0,0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0,1);

    // reset, then R-type add/sub/slt/or with zero wait states
    add(1, OP_R, FN_ADD, 0, 1, E_ZERO,    "reset");
    add(1, OP_R, FN_ADD, 0, 1, E_ZERO,    "reset_hold");
    add(0, OP_R, FN_ADD, 0, 1, E_FETCH_R, "add_fetch");
    add(0, OP_R, FN_ADD, 0, 1, E_DECODE,  "add_decode");
    add(0, OP_R, FN_ADD, 0, 1, E_EXR_ADD, "add_exec");
    add(0, OP_R, FN_ADD, 0, 1, E_WB_R,    "add_wb");
    add(0, OP_R, FN_SUB, 0, 1, E_FETCH_R, "sub_fetch");
    add(0, OP_R, FN_SUB, 0, 1, E_DECODE,  "sub_decode");
    add(0, OP_R, FN_SUB, 0, 1, E_EXR_SUB, "sub_exec");
    add(0, OP_R, FN_SUB, 0, 1, E_WB_R,    "sub_wb");
    add(0, OP_R, FN_SLT, 0, 1, E_FETCH_R, "slt_fetch");
    add(0, OP_R, FN_SLT, 0, 1, E_DECODE,  "slt_decode");
    add(0, OP_R, FN_SLT, 0, 1, E_EXR_SLT, "slt_exec");
    add(0, OP_R, FN_SLT, 0, 1, E_WB_R,    "slt_wb");
    add(0, OP_R, FN_OR,  0, 1, E_FETCH_R, "or_fetch");
    add(0, OP_R, FN_OR,  0, 1, E_DECODE,  "or_decode");
    add(0, OP_R, FN_OR,  0, 1, E_EXR_OR,  "or_exec");
    add(0, OP_R, FN_OR,  0, 1, E_WB_R,    "or_wb");
    // I-type ALU
    add(0, OP_ADDI, 0, 0, 1, E_FETCH_R, "addi_fetch");
    add(0, OP_ADDI, 0, 0, 1, E_DECODE,  "addi_decode");
    add(0, OP_ADDI, 0, 0, 1, E_EXI_ADD, "addi_exec");
    add(0, OP_ADDI, 0, 0, 1, E_WB_I,    "addi_wb");
    add(0, OP_SLTI, 0, 0, 1, E_FETCH_R, "slti_fetch");
    add(0, OP_SLTI, 0, 0, 1, E_DECODE,  "slti_decode");
    add(0, OP_SLTI, 0, 0, 1, E_EXI_SLT, "slti_exec");
    add(0, OP_SLTI, 0, 0, 1, E_WB_I,    "slti_wb");
    // loads and stores, zero wait
    add(0, OP_LW, 0, 0, 1, E_FETCH_R, "lw_fetch");
    add(0, OP_LW, 0, 0, 1, E_DECODE,  "lw_decode");
    add(0, OP_LW, 0, 0, 1, E_EXI_ADD, "lw_addr");
    add(0, OP_LW, 0, 0, 1, E_MRD,     "lw_memrd");
    add(0, OP_LW, 0, 0, 1, E_WB_MEM,  "lw_wb");
    add(0, OP_SW, 0, 0, 1, E_FETCH_R, "sw_fetch");
    add(0, OP_SW, 0, 0, 1, E_DECODE,  "sw_decode");
    add(0, OP_SW, 0, 0, 1, E_EXI_ADD, "sw_addr");
    add(0, OP_SW, 0, 0, 1, E_MWR_R,   "sw_memwr");
    // fetch stall, then lw with three stalled MEM_RD cycles (8 cycles total)
    add(0, OP_LW, 0, 0, 0, E_FETCH_W, "lww_fetch_stall0");
    add(0, OP_LW, 0, 0, 0, E_FETCH_W, "lww_fetch_stall1");
    add(0, OP_LW, 0, 0, 1, E_FETCH_R, "lww_fetch");
    add(0, OP_LW, 0, 0, 1, E_DECODE,  "lww_decode");
    add(0, OP_LW, 0, 0, 1, E_EXI_ADD, "lww_addr");
    add(0, OP_LW, 0, 0, 0, E_MRD,     "lww_memrd_stall0");
    add(0, OP_LW, 0, 0, 0, E_MRD,     "lww_memrd_stall1");
    add(0, OP_LW, 0, 0, 0, E_MRD,     "lww_memrd_stall2");
    add(0, OP_LW, 0, 0, 1, E_MRD,     "lww_memrd_done");
    add(0, OP_LW, 0, 0, 1, E_WB_MEM,  "lww_wb");
    // branches and jumps
    add(0, OP_BEQ, 0, 1, 1, E_FETCH_R, "beqt_fetch");
    add(0, OP_BEQ, 0, 1, 1, E_DECODE,  "beqt_decode");
    add(0, OP_BEQ, 0, 1, 1, E_BR_T,    "beqt_branch");
    add(0, OP_BEQ, 0, 0, 1, E_FETCH_R, "beqn_fetch");
    add(0, OP_BEQ, 0, 0, 1, E_DECODE,  "beqn_decode");
    add(0, OP_BEQ, 0, 0, 1, E_BR_N,    "beqn_branch");
    add(0, OP_J,   0, 0, 1, E_FETCH_R, "j_fetch");
    add(0, OP_J,   0, 0, 1, E_DECODE,  "j_decode");
    add(0, OP_J,   0, 0, 1, E_JUMP,    "j_jump");
    add(0, OP_JAL, 0, 0, 1, E_FETCH_R, "jal_fetch");
    add(0, OP_JAL, 0, 0, 1, E_DECODE,  "jal_decode");
    add(0, OP_JAL, 0, 0, 1, E_JAL,     "jal_jal");
    add(0, OP_R, FN_JR, 0, 1, E_FETCH_R, "jr_fetch");
    add(0, OP_R, FN_JR, 0, 1, E_DECODE,  "jr_decode");
    add(0, OP_R, FN_JR, 0, 1, E_JR,      "jr_jr");
    add(0, OP_ADDI, 0, 0, 0, E_FETCH_W,  "after_jr_fetch");
    // bne: branch when enabled (taken on zero=0), illegal otherwise
    add(0, OP_BNE, 0, 0, 1, E_FETCH_R, "bne_fetch");
    add(0, OP_BNE, 0, 0, 1, E_DECODE,  "bne_decode");
`ifdef MULTICYCLE_BNE_EN
    add(0, OP_BNE, 0, 0, 1, E_BR_T,    "bne_branch");
`else
    add(0, OP_BNE, 0, 0, 1, E_TRAP,    "bne_trap");
`endif
    add(1, OP_BNE, 0, 0, 1, E_ZERO,    "bne_reset");
    // illegal opcode traps and stays trapped
    add(0, OP_BAD, 0, 0, 1, E_FETCH_R, "bad_fetch");
    add(0, OP_BAD, 0, 0, 1, E_DECODE,  "bad_decode");
    add(0, OP_BAD, 0, 0, 1, E_TRAP,    "bad_trap0");
    add(0, OP_BAD, 0, 0, 1, E_TRAP,    "bad_trap1");
    add(1, OP_BAD, 0, 0, 1, E_ZERO,    "bad_reset");

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].z, vecs[i].rdy);
      checkOutput($sformatf("%s#%0d", vecs[i].name, i), vecs[i].expv);
    end

    // FETCH starved for 16 cycles traps; TRAP is sticky until reset
    for (int k = 0; k < 16; k++) begin
      applyStimulus(0, OP_ADDI, 0, 0, 0);
      checkOutput($sformatf("to_fetch_wait%0d", k), E_FETCH_W);
    end
    applyStimulus(0, OP_ADDI, 0, 0, 0);
    checkOutput("to_trap", E_TRAP);
    applyStimulus(0, OP_ADDI, 0, 0, 1);
    checkOutput("to_trap_sticky", E_TRAP);
    applyStimulus(1, OP_ADDI, 0, 0, 1);
    checkOutput("to_reset_clears_err", E_ZERO);

    // mem_ready arriving exactly at the timeout count completes normally
    for (int k = 0; k < 15; k++) begin
      applyStimulus(0, OP_ADDI, 0, 0, 0);
      checkOutput($sformatf("edge_fetch_wait%0d", k), E_FETCH_W);
    end
    applyStimulus(0, OP_ADDI, 0, 0, 1);
    checkOutput("edge_fetch_ready", E_FETCH_R);
    applyStimulus(0, OP_ADDI, 0, 0, 1);
    checkOutput("edge_decode", E_DECODE);
    applyStimulus(0, OP_ADDI, 0, 0, 1);
    checkOutput("edge_exec", E_EXI_ADD);
    applyStimulus(0, OP_ADDI, 0, 0, 1);
    checkOutput("edge_wb", E_WB_I);

    // reset in the middle of a stalled store drops MemWrite immediately
    applyStimulus(0, OP_SW, 0, 0, 1);
    checkOutput("rsw_fetch", E_FETCH_R);
    applyStimulus(0, OP_SW, 0, 0, 1);
    checkOutput("rsw_decode", E_DECODE);
    applyStimulus(0, OP_SW, 0, 0, 1);
    checkOutput("rsw_addr", E_EXI_ADD);
    applyStimulus(0, OP_SW, 0, 0, 0);
    checkOutput("rsw_memwr_stall", E_MWR_W);
    rst = 1'b1;
    checkOutput("rsw_async_reset", E_ZERO);
    applyStimulus(1, OP_SW, 0, 0, 1);
    checkOutput("rsw_reset_hold", E_ZERO);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("rsw_next_fetch", E_FETCH_R);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("rsw_next_decode", E_DECODE);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("rsw_next_exec", E_EXR_ADD);
    applyStimulus(0, OP_R, FN_ADD, 0, 1);
    checkOutput("rsw_next_wb", E_WB_R);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
